// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//
// Oversampling UART receiver. The serial line is brought into the clock
// domain through a two-flop synchronizer. A four-state FSM then walks
// through each frame:
//   IDLE  -> START : falling edge seen on the synchronized line
//   START -> DATA  : start bit confirmed low at its centre
//   DATA  -> STOP  : DATA_BITS samples taken, LSB first
//   STOP  -> IDLE  : STOP_BITS samples taken; result reported
// Every sample is taken at a bit centre.
//
// Parameters
//   DATA_BITS     data bits per frame (LSB first)
//   STOP_BITS     stop bits per frame (1 or 2)
//   OVERSAMPLING  clk cycles per bit period (even, >= 4)
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   rx         in   serial line, idles high, asynchronous to clk
//   data_out   out  last received word; held until the next frame ends
//   valid      out  one-cycle pulse, data_out holds a correctly framed word
//   frame_err  out  one-cycle pulse, a stop bit was sampled low
//   busy       out  high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int OVERSAMPLING = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CNT_W  = $clog2(OVERSAMPLING);
  // The bit counter also walks the stop bits, so size it for whichever
  // count is larger.
  localparam int BMAX   = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
  localparam int BCNT_W = (BMAX > 1) ? $clog2(BMAX) : 1;

  localparam logic [CNT_W-1:0]  HALF_BIT  = CNT_W'(OVERSAMPLING / 2 - 1);
  localparam logic [CNT_W-1:0]  FULL_BIT  = CNT_W'(OVERSAMPLING - 1);
  localparam logic [BCNT_W-1:0] LAST_DATA = BCNT_W'(DATA_BITS - 1);
  localparam logic [BCNT_W-1:0] LAST_STOP = BCNT_W'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [BCNT_W-1:0]     bcnt;
  logic [DATA_BITS-1:0]  shreg;
  logic                  stop_err;
  logic                  rx_meta;
  logic                  rx_s;

  // Shift a new bit in at the MSB, moving earlier bits toward the LSB so
  // that the first bit received ends up in bit 0. Written bitwise so it
  // also elaborates cleanly for DATA_BITS == 1.
  function automatic logic [DATA_BITS-1:0] shift_in(
    input logic [DATA_BITS-1:0] cur,
    input logic                 b
  );
    logic [DATA_BITS-1:0] res;
    res = cur >> 1;
    res[DATA_BITS-1] = b;
    return res;
  endfunction

  // Synchronizer, frame FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      bcnt      <= '0;
      shreg     <= '0;
      stop_err  <= 1'b0;
      data_out  <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_s      <= rx_meta;
      // Result strobes are single-cycle; they are set only in the
      // terminal STOP branch below.
      valid     <= 1'b0;
      frame_err <= 1'b0;

      case (state)
        IDLE: begin
          cnt  <= '0;
          bcnt <= '0;
          if (!rx_s) begin
            state <= START;
            busy  <= 1'b1;
          end else begin
            busy  <= 1'b0;
          end
        end

        START: begin
          if (cnt == HALF_BIT) begin
            cnt  <= '0;
            bcnt <= '0;
            if (!rx_s) begin
              state    <= DATA;
              stop_err <= 1'b0;
            end else begin
              // Line went high again before mid start bit: a glitch,
              // dropped silently.
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (cnt == FULL_BIT) begin
            shreg <= shift_in(shreg, rx_s);
            cnt   <= '0;
            if (bcnt == LAST_DATA) begin
              state <= STOP;
              bcnt  <= '0;
            end else begin
              bcnt <= bcnt + BCNT_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        STOP: begin
          if (cnt == FULL_BIT) begin
            cnt <= '0;
            if (bcnt == LAST_STOP) begin
              // Leave at the centre of the last stop bit so that a start
              // bit immediately following is still caught from IDLE.
              state    <= IDLE;
              busy     <= 1'b0;
              bcnt     <= '0;
              data_out <= shreg;
              stop_err <= 1'b0;
              if (stop_err || !rx_s) begin
                frame_err <= 1'b1;
              end else begin
                valid <= 1'b1;
              end
            end else begin
              bcnt <= bcnt + BCNT_W'(1);
              if (!rx_s) begin
                stop_err <= 1'b1;
              end else begin
                stop_err <= stop_err;
              end
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
          bcnt  <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
//
// Self-checking bench for uart_rx. Two instances: dut (8N1, 16x) and
// dut2 (8 data, 2 stop, 16x). Each frame sent pushes its expected outcome
// (completion cycle, data, kind) onto a per-instance queue; a negedge
// monitor records every valid/frame_err cycle into an observed queue, and
// the test tasks pop both and compare.
//
// Latency: rx changes at a negedge, two synchronizer edges later rx_s is
// low (cycle t0), and the result pulse is in cycle t0+153, i.e. the
// monitor sees it with cyc = send_cyc + 155 (+16 per extra stop bit).
// ---------------------------------------------------------------------------
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx1 = 1'b1;
  logic       rx2 = 1'b1;
  logic [7:0] dout1, dout2;
  logic       v1, fe1, b1, v2, fe2, b2;

  always #5 clk = ~clk;

  uart_rx #(.DATA_BITS(8), .STOP_BITS(1), .OVERSAMPLING(16)) dut (
    .clk(clk), .rst(rst), .rx(rx1),
    .data_out(dout1), .valid(v1), .frame_err(fe1), .busy(b1)
  );

  uart_rx #(.DATA_BITS(8), .STOP_BITS(2), .OVERSAMPLING(16)) dut2 (
    .clk(clk), .rst(rst), .rx(rx2),
    .data_out(dout2), .valid(v2), .frame_err(fe2), .busy(b2)
  );

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic [1:0] kind;   // {frame_err, valid}
  } ev_t;

  ev_t exp1[$], exp2[$], obs1[$], obs2[$];
  int  cyc   = 0;
  int  total = 0;
  int  bad   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (v1 || fe1) obs1.push_back('{cyc, dout1, {fe1, v1}});
    if (v2 || fe2) obs2.push_back('{cyc, dout2, {fe2, v2}});
  end

  task automatic drive_bit(input int which, input logic b);
    if (which == 1) rx1 = b; else rx2 = b;
    repeat (16) @(negedge clk);
  endtask

  // Sends one frame and pushes its expected outcome to the scoreboard.
  task automatic send_frame(input int which, input logic [7:0] d,
                            input logic s1, input logic s2, input int nstop);
    ev_t e;
    logic err;
    err    = !s1 || (nstop == 2 && !s2);
    e.cyc  = cyc + 155 + 16 * (nstop - 1);
    e.data = d;
    e.kind = err ? 2'b10 : 2'b01;
    if (which == 1) exp1.push_back(e); else exp2.push_back(e);
    drive_bit(which, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(which, d[i]);
    drive_bit(which, s1);
    if (nstop == 2) drive_bit(which, s2);
    if (which == 1) rx1 = 1'b1; else rx2 = 1'b1;
  endtask

  // Bounded wait for n observed events; no comparison here.
  task automatic wait_obs(input int which, input int n, input int budget,
                          output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if ((which == 1 ? obs1.size() : obs2.size()) >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if ((which == 1 ? obs1.size() : obs2.size()) >= n) ok = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total += 4;
    if (dout1 !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", dout1); end
    if (v1 !== 1'b0)     begin bad++; $display("FAIL reset_valid got=%b want=0", v1); end
    if (fe1 !== 1'b0)    begin bad++; $display("FAIL reset_ferr got=%b want=0", fe1); end
    if (b1 !== 1'b0)     begin bad++; $display("FAIL reset_busy got=%b want=0", b1); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_good_frame();
    bit ok;
    ev_t e, o;
    send_frame(1, 8'hA5, 1'b1, 1'b1, 1);
    wait_obs(1, 1, 50, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL good_timeout got=%0d events want=1", obs1.size());
    end else begin
      e = exp1.pop_front(); o = obs1.pop_front();
      total += 3;
      if (o.cyc !== e.cyc)   begin bad++; $display("FAIL good_cycle got=%0d want=%0d", o.cyc, e.cyc); end
      if (o.data !== e.data) begin bad++; $display("FAIL good_data got=%h want=%h", o.data, e.data); end
      if (o.kind !== e.kind) begin bad++; $display("FAIL good_kind got=%b want=%b", o.kind, e.kind); end
    end
    repeat (30) @(negedge clk);
    total += 3;
    if (obs1.size() != 0) begin bad++; $display("FAIL good_extra got=%0d events want=0", obs1.size()); obs1.delete(); end
    if (dout1 !== 8'hA5)  begin bad++; $display("FAIL good_hold got=%h want=a5", dout1); end
    if (b1 !== 1'b0)      begin bad++; $display("FAIL good_busy got=%b want=0", b1); end
  endtask

  task automatic test_frame_err();
    bit ok;
    ev_t e, o;
    send_frame(1, 8'h3C, 1'b0, 1'b1, 1);
    wait_obs(1, 1, 50, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL ferr_timeout got=%0d events want=1", obs1.size());
    end else begin
      e = exp1.pop_front(); o = obs1.pop_front();
      total += 3;
      if (o.cyc !== e.cyc)   begin bad++; $display("FAIL ferr_cycle got=%0d want=%0d", o.cyc, e.cyc); end
      if (o.data !== e.data) begin bad++; $display("FAIL ferr_data got=%h want=%h", o.data, e.data); end
      if (o.kind !== e.kind) begin bad++; $display("FAIL ferr_kind got=%b want=%b", o.kind, e.kind); end
    end
    repeat (40) @(negedge clk);
    total += 2;
    if (obs1.size() != 0) begin bad++; $display("FAIL ferr_extra got=%0d events want=0", obs1.size()); obs1.delete(); end
    if (dout1 !== 8'h3C)  begin bad++; $display("FAIL ferr_hold got=%h want=3c", dout1); end
  endtask

  task automatic test_glitch();
    rx1 = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (b1 !== 1'b1) begin bad++; $display("FAIL glitch_busy_hi got=%b want=1", b1); end
    rx1 = 1'b1;
    repeat (30) @(negedge clk);
    total += 2;
    if (b1 !== 1'b0)      begin bad++; $display("FAIL glitch_busy_lo got=%b want=0", b1); end
    if (obs1.size() != 0) begin bad++; $display("FAIL glitch_event got=%0d events want=0", obs1.size()); obs1.delete(); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    ev_t e, o;
    send_frame(1, 8'h00, 1'b1, 1'b1, 1);
    send_frame(1, 8'hFF, 1'b1, 1'b1, 1);
    wait_obs(1, 2, 50, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL b2b_timeout got=%0d events want=2", obs1.size());
      obs1.delete(); exp1.delete();
    end else begin
      for (int k = 0; k < 2; k++) begin
        e = exp1.pop_front(); o = obs1.pop_front();
        total += 3;
        if (o.cyc !== e.cyc)   begin bad++; $display("FAIL b2b_cycle%0d got=%0d want=%0d", k, o.cyc, e.cyc); end
        if (o.data !== e.data) begin bad++; $display("FAIL b2b_data%0d got=%h want=%h", k, o.data, e.data); end
        if (o.kind !== e.kind) begin bad++; $display("FAIL b2b_kind%0d got=%b want=%b", k, o.kind, e.kind); end
      end
    end
    repeat (30) @(negedge clk);
    total++;
    if (obs1.size() != 0) begin bad++; $display("FAIL b2b_extra got=%0d events want=0", obs1.size()); obs1.delete(); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    ev_t e, o;
    logic [7:0] d;
    d = 8'h55;
    drive_bit(1, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1, d[i]);
    rx1 = d[3];
    repeat (8) @(negedge clk);
    rst = 1'b1;
    rx1 = 1'b1;
    repeat (2) @(negedge clk);
    total += 4;
    if (dout1 !== 8'h00) begin bad++; $display("FAIL rmid_data got=%h want=00", dout1); end
    if (b1 !== 1'b0)     begin bad++; $display("FAIL rmid_busy got=%b want=0", b1); end
    if (v1 !== 1'b0)     begin bad++; $display("FAIL rmid_valid got=%b want=0", v1); end
    if (fe1 !== 1'b0)    begin bad++; $display("FAIL rmid_ferr got=%b want=0", fe1); end
    rst = 1'b0;
    repeat (200) @(negedge clk);
    total++;
    if (obs1.size() != 0) begin bad++; $display("FAIL rmid_pulse got=%0d events want=0", obs1.size()); obs1.delete(); end
    send_frame(1, 8'h81, 1'b1, 1'b1, 1);
    wait_obs(1, 1, 50, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL rmid_timeout got=%0d events want=1", obs1.size());
    end else begin
      e = exp1.pop_front(); o = obs1.pop_front();
      total += 3;
      if (o.cyc !== e.cyc)   begin bad++; $display("FAIL rmid_cycle got=%0d want=%0d", o.cyc, e.cyc); end
      if (o.data !== e.data) begin bad++; $display("FAIL rmid_after_data got=%h want=%h", o.data, e.data); end
      if (o.kind !== e.kind) begin bad++; $display("FAIL rmid_kind got=%b want=%b", o.kind, e.kind); end
    end
    repeat (30) @(negedge clk);
  endtask

  task automatic test_two_stop();
    bit ok;
    ev_t e, o;
    // good frame, then second stop bit low, then first stop bit low
    send_frame(2, 8'h5A, 1'b1, 1'b1, 2);
    repeat (20) @(negedge clk);
    send_frame(2, 8'hC3, 1'b1, 1'b0, 2);
    repeat (40) @(negedge clk);
    send_frame(2, 8'h96, 1'b0, 1'b1, 2);
    wait_obs(2, 3, 60, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL stop2_timeout got=%0d events want=3", obs2.size());
      obs2.delete(); exp2.delete();
    end else begin
      for (int k = 0; k < 3; k++) begin
        e = exp2.pop_front(); o = obs2.pop_front();
        total += 3;
        if (o.cyc !== e.cyc)   begin bad++; $display("FAIL stop2_cycle%0d got=%0d want=%0d", k, o.cyc, e.cyc); end
        if (o.data !== e.data) begin bad++; $display("FAIL stop2_data%0d got=%h want=%h", k, o.data, e.data); end
        if (o.kind !== e.kind) begin bad++; $display("FAIL stop2_kind%0d got=%b want=%b", k, o.kind, e.kind); end
      end
    end
    repeat (40) @(negedge clk);
    total += 2;
    if (obs2.size() != 0) begin bad++; $display("FAIL stop2_extra got=%0d events want=0", obs2.size()); obs2.delete(); end
    if (obs1.size() != 0) begin bad++; $display("FAIL stop2_idle_dut got=%0d events want=0", obs1.size()); obs1.delete(); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_frame_err();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    test_two_stop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_BITS, default 8: number of data bits per frame, LSB first.
REQ-002 Parameter STOP_BITS, default 1: number of stop bits per frame, 1 or 2.
REQ-003 Parameter OVERSAMPLING, default 16: clk cycles per bit period; even, at least 4.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 rx  input  1  serial line; idles high; asynchronous to clk.
REQ-007 data_out  output  DATA_BITS  last received data word.
REQ-008 valid  output  1  one-cycle pulse: data_out holds a correctly framed word.
REQ-009 frame_err  output  1  one-cycle pulse: a stop bit was sampled low.
REQ-010 busy  output  1  high whenever state is not IDLE.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer (rx_s); rx_s flops SHALL reset to 1; all FSM decisions SHALL use rx_s only.
REQ-012 The FSM SHALL have states IDLE, START, DATA and STOP, with a bit-period counter cnt and a bit counter bcnt.
REQ-013 In IDLE with rx_s==0, the FSM SHALL go to START and clear cnt; t0 denotes this cycle.
REQ-014 In START, cnt SHALL increment each cycle; at cnt==OVERSAMPLING/2-1, the FSM SHALL act on rx_s:
- rx_s==0: go to DATA, clear cnt and bcnt.
- rx_s==1: false start; go to IDLE, with no valid and no frame_err.
REQ-015 In DATA, at cnt==OVERSAMPLING-1 the FSM SHALL:
- shift rx_s into a shift register at the MSB, shifting right, so the first bit lands at LSB;
- clear cnt;
- go to STOP and clear bcnt if bcnt==DATA_BITS-1; otherwise increment bcnt.
REQ-016 In STOP, a sample SHALL be taken at each cnt==OVERSAMPLING-1, with cnt cleared per stop bit; a sticky error flag SHALL be set if any stop sample is 0.
REQ-017 At the last stop sample, the FSM SHALL:
- return to IDLE;
- load data_out from the shift register;
- in the next cycle, pulse valid if all stop samples were 1, otherwise pulse frame_err.
REQ-018 valid and frame_err SHALL be high for exactly one cycle and SHALL never be high together.
REQ-019 data_out SHALL hold its value until the next frame completes; it is also loaded on a framing error.
REQ-020 For OVERSAMPLING=16, DATA_BITS=8, STOP_BITS=1, valid/frame_err SHALL be high in cycle t0+153, and each sample SHALL fall at the bit center.
REQ-021 The FSM SHALL return to IDLE at the centre of the last stop bit, so a start bit following back-to-back is detected without loss.
REQ-022 rx activity during DATA/STOP other than the sample points SHALL be ignored (no glitch filtering).
REQ-023 cnt SHALL be $clog2(OVERSAMPLING) bits wide; bcnt SHALL be wide enough to hold DATA_BITS-1.

Reset
REQ-024 When rst is high at a clk edge, the block SHALL load:
- state=IDLE, cnt=0, bcnt=0, shift register=0;
- data_out=0, valid=0, frame_err=0, busy=0;
- rx_s flops=1.
REQ-025 A reset asserted mid-frame SHALL abort the frame with no valid/frame_err pulse; after reset release, reception SHALL restart only on a new falling edge of rx_s.

Verification
REQ-026 Frame 0xA5 with 1 stop bit at 16 clk/bit -> data_out=0xA5; valid high for one cycle at t0+153; frame_err stays 0.
REQ-027 Frame 0x3C with stop bit driven low -> frame_err pulses once; data_out=0x3C; valid stays 0.
REQ-028 rx low for 4 cycles, then high (glitch) -> FSM returns to IDLE; busy drops; no valid; no frame_err.
REQ-029 Frames 0x00 then 0xFF back-to-back with no idle gap -> two valid pulses; data_out=0x00, then 0xFF.
REQ-030 rst pulsed during DATA bit 3 -> all outputs at reset values; no pulse; the next full frame 0x81 is received correctly.
REQ-031 STOP_BITS=2 with second stop bit low -> frame_err pulses; the first stop bit alone does not clear the error.
